// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle instruction sequencer for the 8-bit RISC CPU. Every instruction
// is stepped through eight phases:
//   IADDR -> IFETCH -> ILOAD -> IDLE -> OADDR -> OFETCH -> ALU -> STORE
// A ninth state, HALT, is absorbing and is left only through reset.
// IFETCH and OFETCH each stretch to 1 + MEM_WAIT cycles for slow memory.
//
// Parameters
//   OPCODE_W  opcode width (>= 3). Bits above [2:0] must be zero for a valid
//             opcode; any nonzero upper bit decodes as HLT.
//   MEM_WAIT  extra wait cycles per memory-fetch phase, 0..15.
//   CNT_W     width of the retired-instruction counter.
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   load_in  in   program-load mode; parks the CPU at IADDR
//   opcode   in   opcode field from the IR
//   zero     in   accumulator-zero flag
//   sel      out  address mux select (1 = PC, 0 = IR operand)
//   rd       out  memory read strobe
//   wr       out  memory write strobe
//   ld_ir    out  instruction register load
//   ld_ac    out  accumulator load
//   ld_pc    out  program counter parallel load (jump)
//   inc_pc   out  program counter increment
//   data_e   out  accumulator drives the data bus
//   halt     out  CPU halted
//   alu_op   out  opcode captured on entry to OADDR, presented to the ALU
//   retired  out  retired-instruction count
//
// Build option
//   CPU_SEQ_RETIRE_CNT_EN  when defined, retired counts STORE -> IADDR
//                          transitions and saturates at all-ones. When
//                          undefined, retired is tied to zero and the counter
//                          does not exist.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int OPCODE_W = 3,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_in,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                data_e,
    output logic                halt,
    output logic [2:0]          alu_op,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [3:0] {
        S_IADDR  = 4'd0,
        S_IFETCH = 4'd1,
        S_ILOAD  = 4'd2,
        S_IDLE   = 4'd3,
        S_OADDR  = 4'd4,
        S_OFETCH = 4'd5,
        S_ALU    = 4'd6,
        S_STORE  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Terminal value of the wait counter: a fetch phase ends on the cycle
    // the counter equals this value.
    localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    logic [3:0] w_wait_next;
    logic [2:0] r_alu_op;

    logic [2:0] w_op;
    logic       w_is_hlt;
    logic       w_is_skz;
    logic       w_is_jmp;
    logic       w_is_sto;
    logic       w_is_aluop;
    logic       w_wait_done;

    // Opcode decode. Any set bit above [2:0] makes the opcode invalid, and
    // an invalid opcode is treated as HLT so the CPU stops safely. The shift
    // keeps this legal for OPCODE_W == 3, where no upper bits exist.
    assign w_op       = ((opcode >> 3) != '0) ? OP_HLT : opcode[2:0];
    assign w_is_hlt   = (w_op == OP_HLT);
    assign w_is_skz   = (w_op == OP_SKZ);
    assign w_is_jmp   = (w_op == OP_JMP);
    assign w_is_sto   = (w_op == OP_STO);
    assign w_is_aluop = (w_op == OP_ADD) || (w_op == OP_AND) ||
                        (w_op == OP_XOR) || (w_op == OP_LDA);

    assign w_wait_done = (r_wait == LP_WAIT);

    // State, wait counter and ALU opcode registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IADDR;
            r_wait   <= 4'd0;
            r_alu_op <= 3'b000;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            // IDLE always advances to OADDR, so this edge is the OADDR entry.
            if (r_state == S_IDLE) begin
                r_alu_op <= opcode[2:0];
            end
        end
    end

    // Next-state and Moore-style output decode.
    always_comb begin
        w_next      = r_state;
        w_wait_next = 4'd0;
        sel         = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        ld_ir       = 1'b0;
        ld_ac       = 1'b0;
        ld_pc       = 1'b0;
        inc_pc      = 1'b0;
        data_e      = 1'b0;
        halt        = 1'b0;

        case (r_state)
            S_IADDR: begin
                // Program-load mode parks the CPU here with every output low,
                // including sel, so the loader owns the address bus.
                if (!load_in) begin
                    sel    = 1'b1;
                    w_next = S_IFETCH;
                end
            end

            S_IFETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
                if (w_wait_done) begin
                    w_next = S_ILOAD;
                end else begin
                    w_wait_next = r_wait + 4'd1;
                end
            end

            S_ILOAD: begin
                sel    = 1'b1;
                rd     = 1'b1;
                ld_ir  = 1'b1;
                w_next = S_IDLE;
            end

            S_IDLE: begin
                sel    = 1'b1;
                rd     = 1'b1;
                ld_ir  = 1'b1;
                w_next = S_OADDR;
            end

            S_OADDR: begin
                inc_pc = 1'b1;
                if (w_is_hlt) begin
                    halt   = 1'b1;
                    w_next = S_HALT;
                end else begin
                    w_next = S_OFETCH;
                end
            end

            S_OFETCH: begin
                rd = w_is_aluop;
                if (w_wait_done) begin
                    w_next = S_ALU;
                end else begin
                    w_wait_next = r_wait + 4'd1;
                end
            end

            S_ALU: begin
                rd     = w_is_aluop;
                ld_ac  = w_is_aluop;
                // Skip: a second PC increment steps over the next instruction.
                inc_pc = w_is_skz & zero;
                ld_pc  = w_is_jmp;
                data_e = w_is_sto;
                w_next = S_STORE;
            end

            S_STORE: begin
                rd     = w_is_aluop;
                ld_ac  = w_is_aluop;
                ld_pc  = w_is_jmp;
                inc_pc = w_is_jmp;
                wr     = w_is_sto;
                data_e = w_is_sto;
                // load_in is not sampled here; a pending load parks the FSM
                // at IADDR after this instruction retires.
                w_next = S_IADDR;
            end

            S_HALT: begin
                halt = 1'b1;
            end

            default: begin
                // Unreachable encodings recover to the start of a cycle.
                w_next = S_IADDR;
            end
        endcase
    end

    assign alu_op = r_alu_op;

`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired;

    // STORE always proceeds to IADDR, so every STORE cycle retires one
    // instruction. HLT never reaches STORE and is therefore not counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if ((r_state == S_STORE) && (r_retired != '1)) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed bench for cpu_sequencer. Two instances share the input stimulus:
// u_dut0 with MEM_WAIT = 0 and u_dut3 with MEM_WAIT = 3. Outputs are packed
// as {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt} and compared
// against hand-written per-cycle tables one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       load_in;
    logic [2:0] opcode;
    logic       zero;

    logic        sel0, rd0, wr0, ld_ir0, ld_ac0, ld_pc0, inc_pc0, data_e0, halt0;
    logic [2:0]  alu_op0;
    logic [15:0] retired0;
    logic        sel3, rd3, wr3, ld_ir3, ld_ac3, ld_pc3, inc_pc3, data_e3, halt3;
    logic [2:0]  alu_op3;
    logic [15:0] retired3;

    logic [8:0] o0;
    logic [8:0] o3;
    assign o0 = {sel0, rd0, wr0, ld_ir0, ld_ac0, ld_pc0, inc_pc0, data_e0, halt0};
    assign o3 = {sel3, rd3, wr3, ld_ir3, ld_ac3, ld_pc3, inc_pc3, data_e3, halt3};

`ifdef CPU_SEQ_RETIRE_CNT_EN
    localparam int RC_EN = 1;
`else
    localparam int RC_EN = 0;
`endif

    int errors = 0;
    int checks = 0;

    cpu_sequencer #(.OPCODE_W(3), .MEM_WAIT(0), .CNT_W(16)) u_dut0 (
        .clock(clock), .reset(reset), .load_in(load_in), .opcode(opcode), .zero(zero),
        .sel(sel0), .rd(rd0), .wr(wr0), .ld_ir(ld_ir0), .ld_ac(ld_ac0), .ld_pc(ld_pc0),
        .inc_pc(inc_pc0), .data_e(data_e0), .halt(halt0), .alu_op(alu_op0),
        .retired(retired0)
    );

    cpu_sequencer #(.OPCODE_W(3), .MEM_WAIT(3), .CNT_W(16)) u_dut3 (
        .clock(clock), .reset(reset), .load_in(load_in), .opcode(opcode), .zero(zero),
        .sel(sel3), .rd(rd3), .wr(wr3), .ld_ir(ld_ir3), .ld_ac(ld_ac3), .ld_pc(ld_pc3),
        .inc_pc(inc_pc3), .data_e(data_e3), .halt(halt3), .alu_op(alu_op3),
        .retired(retired3)
    );

    function automatic logic [15:0] exp_ret(input int n);
        return (RC_EN != 0) ? 16'(n) : 16'd0;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves both DUTs in their first IADDR cycle, one unit after an edge.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        opcode  = 3'b010;
        zero    = 1'b0;
        load_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (o0 !== 9'b100000000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", o0, 9'b100000000); end
        checks++; if (o3 !== 9'b100000000) begin errors++; $display("FAIL reset_outputs_w3: got %b expected %b", o3, 9'b100000000); end
        checks++; if (alu_op0 !== 3'b000) begin errors++; $display("FAIL reset_alu_op: got %b expected 000", alu_op0); end
        checks++; if (retired0 !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired0); end
        load_in = 1'b1;
        #1;
        checks++; if (o0 !== 9'b000000000) begin errors++; $display("FAIL reset_load_sel: got %b expected %b", o0, 9'b000000000); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o0 !== 9'b000000000) begin errors++; $display("FAIL load_hold_after_reset cycle %0d: got %b expected %b", i, o0, 9'b000000000); end
        end
        load_in = 1'b0;
        #1;
        checks++; if (o0 !== 9'b100000000) begin errors++; $display("FAIL load_release_iaddr: got %b expected %b", o0, 9'b100000000); end
        step();
        checks++; if (o0 !== 9'b110000000) begin errors++; $display("FAIL first_ifetch: got %b expected %b", o0, 9'b110000000); end
        // Walk IFETCH -> ILOAD -> IDLE -> OADDR -> OFETCH -> ALU, then abort.
        for (int i = 0; i < 5; i++) step();
        checks++; if (o0 !== 9'b010010000) begin errors++; $display("FAIL abort_pre_alu: got %b expected %b", o0, 9'b010010000); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (o0 !== 9'b100000000) begin errors++; $display("FAIL abort_outputs: got %b expected %b", o0, 9'b100000000); end
        step();
        checks++; if (retired0 !== 16'd0) begin errors++; $display("FAIL abort_retired: got %0d expected 0", retired0); end
    endtask

    task automatic test_add();
        logic [8:0] exp [0:8];
        exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000, 9'b000000100,
                9'b010000000, 9'b010010000, 9'b010010000, 9'b100000000};
        opcode  = 3'b010;
        zero    = 1'b0;
        load_in = 1'b0;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            checks++; if (o0 !== exp[i]) begin errors++; $display("FAIL add_outputs cycle %0d: got %b expected %b", i, o0, exp[i]); end
            checks++; if (alu_op0 !== ((i >= 4) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL add_alu_op cycle %0d: got %b", i, alu_op0); end
            if (i < 8) step();
        end
    endtask

    task automatic test_skz();
        logic [8:0] exp [0:8];
        int pulses;
        for (int z = 1; z >= 0; z--) begin
            exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000, 9'b000000100,
                    9'b000000000, 9'b000000000, 9'b000000000, 9'b100000000};
            if (z == 1) exp[6] = 9'b000000100;
            opcode  = 3'b001;
            zero    = z[0];
            load_in = 1'b0;
            apply_reset();
            pulses = 0;
            for (int i = 0; i < 9; i++) begin
                checks++; if (o0 !== exp[i]) begin errors++; $display("FAIL skz_z%0d_outputs cycle %0d: got %b expected %b", z, i, o0, exp[i]); end
                if (i < 8 && inc_pc0 === 1'b1) pulses++;
                if (i < 8) step();
            end
            checks++; if (pulses !== z + 1) begin errors++; $display("FAIL skz_z%0d_pulses: got %0d expected %0d", z, pulses, z + 1); end
            checks++; if (alu_op0 !== 3'b001) begin errors++; $display("FAIL skz_alu_op: got %b expected 001", alu_op0); end
        end
    endtask

    // JMP followed immediately by STO without an intervening reset.
    task automatic test_back_to_back();
        logic [8:0] exp_j [0:8];
        logic [8:0] exp_s [0:8];
        exp_j = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000, 9'b000000100,
                  9'b000000000, 9'b000001000, 9'b000001100, 9'b100000000};
        exp_s = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000, 9'b000000100,
                  9'b000000000, 9'b000000010, 9'b001000010, 9'b100000000};
        opcode  = 3'b111;
        zero    = 1'b1;
        load_in = 1'b0;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (o0 !== exp_j[i]) begin errors++; $display("FAIL jmp_outputs cycle %0d: got %b expected %b", i, o0, exp_j[i]); end
            step();
        end
        opcode = 3'b110;
        for (int i = 0; i < 9; i++) begin
            checks++; if (o0 !== exp_s[i]) begin errors++; $display("FAIL sto_outputs cycle %0d: got %b expected %b", i, o0, exp_s[i]); end
            checks++; if (alu_op0 !== ((i >= 4) ? 3'b110 : 3'b111)) begin errors++; $display("FAIL sto_alu_op cycle %0d: got %b", i, alu_op0); end
            if (i < 8) step();
        end
    endtask

    task automatic test_mem_wait();
        logic [8:0] exp [0:14];
        exp = '{9'b100000000,
                9'b110000000, 9'b110000000, 9'b110000000, 9'b110000000,
                9'b110100000, 9'b110100000, 9'b000000100,
                9'b010000000, 9'b010000000, 9'b010000000, 9'b010000000,
                9'b010010000, 9'b010010000, 9'b100000000};
        opcode  = 3'b010;
        zero    = 1'b0;
        load_in = 1'b0;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            checks++; if (o3 !== exp[i]) begin errors++; $display("FAIL wait3_outputs cycle %0d: got %b expected %b", i, o3, exp[i]); end
            if (i < 14) step();
        end
        checks++; if (alu_op3 !== 3'b010) begin errors++; $display("FAIL wait3_alu_op: got %b expected 010", alu_op3); end
    endtask

    task automatic test_halt();
        logic [8:0] exp [0:4];
        exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000, 9'b000000101};
        opcode  = 3'b000;
        zero    = 1'b0;
        load_in = 1'b0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            checks++; if (o0 !== exp[i]) begin errors++; $display("FAIL hlt_outputs cycle %0d: got %b expected %b", i, o0, exp[i]); end
            step();
        end
        for (int i = 0; i < 100; i++) begin
            if (i == 50) load_in = 1'b1;
            checks++; if (o0 !== 9'b000000001) begin errors++; $display("FAIL halt_hold cycle %0d: got %b expected %b", i, o0, 9'b000000001); end
            step();
        end
        load_in = 1'b0;
        checks++; if (o3 !== 9'b000000001) begin errors++; $display("FAIL halt_w3: got %b expected %b", o3, 9'b000000001); end
        checks++; if (retired0 !== 16'd0) begin errors++; $display("FAIL halt_retired: got %0d expected 0", retired0); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (o0 !== 9'b100000000) begin errors++; $display("FAIL halt_reset_exit: got %b expected %b", o0, 9'b100000000); end
    endtask

    task automatic test_load_retire();
        opcode  = 3'b010;
        zero    = 1'b0;
        load_in = 1'b0;
        apply_reset();
        for (int i = 0; i < 6; i++) step();
        checks++; if (o0 !== 9'b010010000) begin errors++; $display("FAIL load_at_alu: got %b expected %b", o0, 9'b010010000); end
        load_in = 1'b1;
        step();
        checks++; if (o0 !== 9'b010010000) begin errors++; $display("FAIL load_store_completes: got %b expected %b", o0, 9'b010010000); end
        step();
        checks++; if (o0 !== 9'b000000000) begin errors++; $display("FAIL load_park: got %b expected %b", o0, 9'b000000000); end
        checks++; if (retired0 !== exp_ret(1)) begin errors++; $display("FAIL retired_one: got %0d expected %0d", retired0, exp_ret(1)); end
        step();
        step();
        checks++; if (o0 !== 9'b000000000) begin errors++; $display("FAIL load_park_hold: got %b expected %b", o0, 9'b000000000); end
        checks++; if (retired0 !== exp_ret(1)) begin errors++; $display("FAIL retired_hold: got %0d expected %0d", retired0, exp_ret(1)); end
        load_in = 1'b0;
        #1;
        checks++; if (o0 !== 9'b100000000) begin errors++; $display("FAIL load_release: got %b expected %b", o0, 9'b100000000); end
        for (int i = 0; i < 8; i++) step();
        checks++; if (o0 !== 9'b100000000) begin errors++; $display("FAIL add2_period: got %b expected %b", o0, 9'b100000000); end
        checks++; if (retired0 !== exp_ret(2)) begin errors++; $display("FAIL retired_two: got %0d expected %0d", retired0, exp_ret(2)); end
        for (int i = 0; i < 7; i++) step();
        checks++; if (o0 !== 9'b010010000) begin errors++; $display("FAIL add3_store: got %b expected %b", o0, 9'b010010000); end
        // load_in rises together with the STORE -> IADDR transition.
        load_in = 1'b1;
        step();
        checks++; if (o0 !== 9'b000000000) begin errors++; $display("FAIL store_load_park: got %b expected %b", o0, 9'b000000000); end
        checks++; if (retired0 !== exp_ret(3)) begin errors++; $display("FAIL retired_three: got %0d expected %0d", retired0, exp_ret(3)); end
        step();
        checks++; if (o0 !== 9'b000000000) begin errors++; $display("FAIL store_load_hold: got %b expected %b", o0, 9'b000000000); end
        load_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        load_in = 1'b0;
        opcode  = 3'b000;
        zero    = 1'b0;
        test_reset();
        test_add();
        test_skz();
        test_back_to_back();
        test_mem_wait();
        test_halt();
        test_load_retire();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle instruction sequencer for the 8-bit RISC CPU. It replaces the single-stage enable controller. It steps every instruction through an eight-phase fetch/decode/execute cycle, with configurable memory wait states. It drives the address-mux select, memory read/write, IR/ACC/PC loads, ALU opcode and halt. It sits between the instruction register/zero flag and the datapath, memory and program counter.

## Interface
Parameters:
- OPCODE_W, 3: opcode width; decoding uses the low 3 bits, and any upper bits must be zero for a valid opcode (nonzero upper bits decode as HLT).
- MEM_WAIT, 0: extra wait cycles inserted in each memory-fetch phase; legal range 0..15.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load_in  in  1  program-load mode; holds the CPU idle.
- opcode  in  OPCODE_W  opcode field from the IR.
- zero  in  1  accumulator-zero flag.
- sel  out  1  address mux: 1 = PC, 0 = IR operand.
- rd  out  1  memory read strobe.
- wr  out  1  memory write strobe.
- ld_ir  out  1  IR load.
- ld_ac  out  1  accumulator load.
- ld_pc  out  1  PC parallel load (jump).
- inc_pc  out  1  PC increment.
- data_e  out  1  accumulator drives the data bus.
- halt  out  1  CPU halted.
- alu_op  out  3  registered opcode presented to the ALU.
- retired  out  CNT_W  retired-instruction count (see Configuration).

## Operation
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP. ALUOP set = {ADD, AND, XOR, LDA}.
- FSM states and phase order: IADDR → IFETCH → ILOAD → IDLE → OADDR → OFETCH → ALU → STORE → IADDR. A ninth state, HALT, is absorbing.
- Outputs are decoded from the state and are 0 unless listed below:
  - IADDR: sel.
  - IFETCH: sel, rd.
  - ILOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OADDR: inc_pc. If opcode = HLT, also assert halt and go to HALT instead of OFETCH.
  - OFETCH: rd if ALUOP.
  - ALU: rd and ld_ac if ALUOP; inc_pc if SKZ and zero = 1; ld_pc if JMP; data_e if STO.
  - STORE: rd and ld_ac if ALUOP; ld_pc and inc_pc if JMP; wr and data_e if STO.
  - HALT: halt only; left only by reset.
- alu_op is registered from opcode[2:0] on the cycle that OADDR is entered and held until the next OADDR.
- Wait states: IFETCH and OFETCH each last 1 + MEM_WAIT cycles, counted by a 4-bit wait counter. Outputs stay constant across all wait cycles.
- load_in = 1 behaviour:
  - At IADDR: the FSM holds in IADDR with every output 0, including sel.
  - In any other state: the current instruction completes normally, and the FSM then holds at IADDR.
  - In HALT: has no effect.

## Timing
- Reset, asynchronous: state = IADDR, wait counter = 0, alu_op = 000, retired = 0.
- After reset, all outputs are 0 except sel = 1. If load_in = 1, sel is also 0.
- First IADDR cycle begins on the first clock edge after reset deasserts with load_in = 0.
- Instruction latency is 8 + 2·MEM_WAIT cycles from IADDR to IADDR.
- HLT reaches HALT 5 + MEM_WAIT cycles after IADDR. halt is high in OADDR and in every cycle after it.
- Reset asserted mid-instruction aborts that instruction immediately. It is not counted as retired.
- Simultaneous load_in rise and STORE → IADDR transition: the instruction retires, and the FSM then holds in IADDR.

## Configuration
- CPU_SEQ_RETIRE_CNT_EN defined: retired increments by 1 on each STORE → IADDR transition and saturates at 2^CNT_W − 1. HLT is not counted.
- CPU_SEQ_RETIRE_CNT_EN undefined: retired is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- MEM_WAIT = 0, reset, ADD at IADDR: sel, rd, ld_ir follow the per-state list; ld_ac = 1 in ALU and STORE; alu_op = 010 from OADDR; back in IADDR after 8 cycles.
- SKZ with zero = 1, then with zero = 0: inc_pc pulses in OADDR and ALU (2 pulses) for zero = 1; inc_pc pulses only in OADDR for zero = 0.
- JMP: ld_pc = 1 in ALU and STORE, inc_pc = 1 in STORE. STO: data_e = 1 in ALU and STORE, wr = 1 in STORE only.
- MEM_WAIT = 3: IFETCH and OFETCH each last 4 cycles with constant outputs; instruction period = 14 cycles.
- HLT: halt rises in OADDR and stays high for 100 cycles with no other strobes. Asserting reset then returns to IADDR with halt = 0.
- load_in pulsed mid-ALU: the instruction completes and the FSM holds in IADDR with all outputs 0. With the macro defined, retired increments by exactly 1; 3 ADDs give retired = 3.
